instr_decode: RTL and testbench
===============================

Name: instr_decode

Overview:
- Decode/dispatch stage directly downstream of the instruction fetch FIFO stage.
- Pops one entry per cycle (thread_id, pc, instr) from the fetch FIFO head, decodes RV32I fields, and generates the sign-extended immediate.
- Classifies the instruction to a target reservation station and holds it in a single output register until that station accepts it.
- Supports a per-thread flush for branch redirects.

Parameters:
XLEN, 32, data/PC width
THREAD_WIDTH, 2, thread id width
INSTR_WIDTH, 32, instruction width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
fifo_empty_i  input  1  fetch FIFO empty; head fields valid when low
thread_id_i  input  THREAD_WIDTH  head thread id
pc_i  input  XLEN  head PC
instr_i  input  INSTR_WIDTH  head instruction
decode_ack_o  output  1  pops FIFO head this cycle
stall_i  input  1  blocks loading new entries
flush_i  input  1  flush request
flush_thread_i  input  THREAD_WIDTH  thread to flush
alu_ready_i  input  1  ALU RS can accept
br_ready_i  input  1  branch RS can accept
lsu_ready_i  input  1  load/store RS can accept
sys_ready_i  input  1  system/exception path can accept
valid_o  output  1  output register holds an instruction
rs_sel_o  output  2  0=ALU, 1=BR, 2=LSU, 3=SYS
thread_id_o  output  THREAD_WIDTH  thread id
pc_o  output  XLEN  PC
rd_o, rs1_o, rs2_o  output  5 each  register specifiers
funct3_o  output  3  funct3
funct7_o  output  7  funct7
imm_o  output  XLEN  sign-extended immediate
illegal_o  output  1  unrecognised opcode

Behaviour:
- Reset (synchronous, rst high at clk edge): valid_o=0; all other registered outputs=0. decode_ack_o=0 while rst is high.
- Head is show-ahead: fields are valid combinationally whenever fifo_empty_i=0. An entry is popped on any cycle decode_ack_o=1.
- fire = valid_o & ready(rs_sel_o), where ready() selects alu/br/lsu/sys_ready_i. On fire, the output is consumed at that clock edge.
- load = !fifo_empty_i & !stall_i & (!valid_o | fire) & !drop.
- drop = flush_i & !fifo_empty_i & (thread_id_i == flush_thread_i).
- decode_ack_o = load | drop. This is combinational; it never asserts while fifo_empty_i=1.
- load: the output register captures the decoded head at the edge and valid_o=1. This gives back-to-back throughput of 1/cycle while the target is ready.
- fire without load: valid_o goes 0 at the next edge.
- No fire with valid_o=1: all outputs hold stable. They are never altered while waiting.
- Flush, output register: if flush_i & valid_o & thread_id_o==flush_thread_i, then valid_o=0 next cycle. This takes priority over hold. A fire in the same cycle still counts as accepted.
- Flush, FIFO head: matching-thread head entries are popped and discarded, one per cycle while flush_i is held. A non-matching head loads normally.
- drop ignores stall_i.
- Classification by opcode[6:0]:
  - 0110011 OP, 0010011 OP-IMM, 0110111 LUI, 0010111 AUIPC -> ALU
  - 1101111 JAL, 1100111 JALR, 1100011 BRANCH -> BR
  - 0000011 LOAD, 0100011 STORE -> LSU
  - 1110011 SYSTEM, 0001111 MISC-MEM -> SYS
  - anything else -> SYS with illegal_o=1
- Immediates:
  - I-type: sign-extend instr[31:20]; used for OP-IMM, LOAD, JALR, SYSTEM.
  - S-type: {instr[31:25], instr[11:7]}, sign-extended.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - OP/illegal: imm_o=0.
- Register fields are extracted unconditionally: rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12], funct7=[31:25].
- Reset mid-operation: a held instruction is discarded and decode_ack_o is forced 0.

Test Plan:
1. Reset, then FIFO head instr=0x00500093 (addi x1,x0,5), thread 1, pc 0x100, alu_ready_i=1 -> decode_ack_o=1 in cycle 0. Next cycle: valid_o=1, rs_sel_o=0, rd_o=1, imm_o=5, thread_id_o=1, pc_o=0x100.
2. instr=0xFE000EE3 (beq, offset -4), br_ready_i=0 for 3 cycles, FIFO non-empty -> outputs held, imm_o=0xFFFFFFFC, rs_sel_o=1, decode_ack_o=0 during the hold. When br_ready_i=1: fire, next entry loaded same edge.
3. 4 ALU instructions queued with alu_ready_i=1 held -> decode_ack_o=1 for 4 consecutive cycles, valid_o=1 for 4 consecutive cycles, no bubbles.
4. valid_o=1 holding thread 2 (lsu not ready); FIFO head thread 2 then thread 0; flush_i=1, flush_thread_i=2 for one cycle -> valid_o=0, thread-2 head popped without load. Next cycle the thread-0 entry loads.
5. instr=0xFFFFFFFF -> rs_sel_o=3, illegal_o=1, imm_o=0. With sys_ready_i=1 it fires.
6. stall_i=1 with FIFO non-empty and valid_o=0 -> decode_ack_o=0, valid_o stays 0. Assert rst while valid_o=1 -> valid_o=0 next edge.

Source files
------------

// File: rtl/instr_decode.sv
// RV32I decode/dispatch stage behind the fetch FIFO.
// Holds one decoded instruction until its reservation station accepts it.
module instr_decode #(
  parameter int XLEN         = 32,
  parameter int THREAD_WIDTH = 2,
  parameter int INSTR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty_i,
  input  logic [THREAD_WIDTH-1:0] thread_id_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [INSTR_WIDTH-1:0]  instr_i,
  output logic                    decode_ack_o,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [THREAD_WIDTH-1:0] flush_thread_i,
  input  logic                    alu_ready_i,
  input  logic                    br_ready_i,
  input  logic                    lsu_ready_i,
  input  logic                    sys_ready_i,
  output logic                    valid_o,
  output logic [1:0]              rs_sel_o,
  output logic [THREAD_WIDTH-1:0] thread_id_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [4:0]              rd_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [2:0]              funct3_o,
  output logic [6:0]              funct7_o,
  output logic [XLEN-1:0]         imm_o,
  output logic                    illegal_o
);

  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_BR  = 2'd1;
  localparam logic [1:0] RS_LSU = 2'd2;
  localparam logic [1:0] RS_SYS = 2'd3;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;

  logic [6:0]      opcode;
  logic [1:0]      sel_d;
  logic            ill_d;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_d;

  assign opcode = instr_i[6:0];

  assign imm_i = XLEN'($signed(instr_i[31:20]));
  assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b = XLEN'($signed({instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0}));
  assign imm_u = XLEN'({instr_i[31:12], 12'b0});
  assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0}));

  always_comb begin
    sel_d = RS_SYS;
    ill_d = 1'b0;
    imm_d = '0;
    unique case (opcode)
      OP_OP: sel_d = RS_ALU;
      OP_IMM: begin
        sel_d = RS_ALU;
        imm_d = imm_i;
      end
      OP_LUI, OP_AUIPC: begin
        sel_d = RS_ALU;
        imm_d = imm_u;
      end
      OP_JAL: begin
        sel_d = RS_BR;
        imm_d = imm_j;
      end
      OP_JALR: begin
        sel_d = RS_BR;
        imm_d = imm_i;
      end
      OP_BRANCH: begin
        sel_d = RS_BR;
        imm_d = imm_b;
      end
      OP_LOAD: begin
        sel_d = RS_LSU;
        imm_d = imm_i;
      end
      OP_STORE: begin
        sel_d = RS_LSU;
        imm_d = imm_s;
      end
      // FENCE carries an I-format immediate (fm/pred/succ)
      OP_SYSTEM, OP_MISC: begin
        sel_d = RS_SYS;
        imm_d = imm_i;
      end
      default: begin
        sel_d = RS_SYS;
        ill_d = 1'b1;
      end
    endcase
  end

  logic ready_sel;
  logic fire, drop, load, flush_hit;

  always_comb begin
    ready_sel = 1'b0;
    unique case (rs_sel_o)
      RS_ALU: ready_sel = alu_ready_i;
      RS_BR:  ready_sel = br_ready_i;
      RS_LSU: ready_sel = lsu_ready_i;
      default: ready_sel = sys_ready_i;
    endcase
  end

  assign fire      = valid_o & ready_sel;
  assign drop      = flush_i & ~fifo_empty_i & (thread_id_i == flush_thread_i);
  assign load      = ~fifo_empty_i & ~stall_i & (~valid_o | fire) & ~drop;
  assign flush_hit = flush_i & valid_o & (thread_id_o == flush_thread_i);

  assign decode_ack_o = ~rst & (load | drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      rs_sel_o    <= '0;
      thread_id_o <= '0;
      pc_o        <= '0;
      rd_o        <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      funct3_o    <= '0;
      funct7_o    <= '0;
      imm_o       <= '0;
      illegal_o   <= 1'b0;
    end else if (load) begin
      valid_o     <= 1'b1;
      rs_sel_o    <= sel_d;
      thread_id_o <= thread_id_i;
      pc_o        <= pc_i;
      rd_o        <= instr_i[11:7];
      rs1_o       <= instr_i[19:15];
      rs2_o       <= instr_i[24:20];
      funct3_o    <= instr_i[14:12];
      funct7_o    <= instr_i[31:25];
      imm_o       <= imm_d;
      illegal_o   <= ill_d;
    end else if (fire | flush_hit) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Randomised scoreboard bench for instr_decode.
// A reference model predicts pops and dispatched instructions.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [1:0]  thread_id;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        decode_ack;
  logic        stall;
  logic        flush;
  logic [1:0]  flush_thread;
  logic [3:0]  rdy;
  logic        valid;
  logic [1:0]  rs_sel;
  logic [1:0]  thread_o;
  logic [31:0] pc_o;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;

  always #5 clk = ~clk;

  instr_decode dut (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty),
    .thread_id_i(thread_id), .pc_i(pc), .instr_i(instr),
    .decode_ack_o(decode_ack), .stall_i(stall), .flush_i(flush),
    .flush_thread_i(flush_thread), .alu_ready_i(rdy[0]),
    .br_ready_i(rdy[1]), .lsu_ready_i(rdy[2]), .sys_ready_i(rdy[3]),
    .valid_o(valid), .rs_sel_o(rs_sel), .thread_id_o(thread_o),
    .pc_o(pc_o), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
    .funct3_o(funct3), .funct7_o(funct7), .imm_o(imm),
    .illegal_o(illegal)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [1:0]  thr;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } rec_t;

  typedef struct packed {
    logic [1:0]  thr;
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int   total = 0;
  int   passed = 0;
  rec_t exp_q[$];
  ent_t fifo[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Immediates rebuilt by integer arithmetic on bit positions.
  function automatic rec_t ref_dec(input logic [1:0] t,
                                   input logic [31:0] p,
                                   input logic [31:0] ins);
    rec_t   r;
    longint u, v;
    int     op;
    u = longint'({32'b0, ins});
    op = int'(u % 128);
    v = 0;
    r.thr = t;
    r.pc  = p;
    r.rd  = 5'((u >> 7) % 32);
    r.rs1 = 5'((u >> 15) % 32);
    r.rs2 = 5'((u >> 20) % 32);
    r.f3  = 3'((u >> 12) % 8);
    r.f7  = 7'((u >> 25) % 128);
    r.ill = 1'b0;
    case (op)
      'h33, 'h13, 'h37, 'h17: r.sel = 2'd0;
      'h6F, 'h67, 'h63:       r.sel = 2'd1;
      'h03, 'h23:             r.sel = 2'd2;
      'h73, 'h0F:             r.sel = 2'd3;
      default: begin
        r.sel = 2'd3;
        r.ill = 1'b1;
      end
    endcase
    case (op)
      'h13, 'h03, 'h67, 'h73, 'h0F: begin
        v = u >> 20;
        if (v >= 2048) v -= 4096;
      end
      'h23: begin
        v = (u >> 25) * 32 + (u >> 7) % 32;
        if (v >= 2048) v -= 4096;
      end
      'h63: begin
        v = ((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
          + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
        if (v >= 4096) v -= 8192;
      end
      'h37, 'h17: v = (u >> 12) * 4096;
      'h6F: begin
        v = ((u >> 31) % 2) * (1 << 20) + ((u >> 12) % 256) * 4096
          + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      default: v = 0;
    endcase
    r.imm = 32'(v);
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
            7'h63, 7'h03, 7'h23, 7'h73, 7'h0F, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 11) != 11)
      w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  // Monitor: every accepted instruction must match the oldest prediction.
  initial begin
    rec_t got, e;
    forever begin
      @(negedge clk);
      if (!rst && valid && rdy[rs_sel]) begin
        got = '{rs_sel, thread_o, pc_o, rd, rs1, rs2,
                funct3, funct7, imm, illegal};
        if (exp_q.size() == 0) begin
          chk("unexpected_fire", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("dispatch", got, e);
        end
      end
    end
  end

  logic       mvalid;
  logic [1:0] msel, mthr;
  logic       mfire, mdrop, mload, mhit;
  logic       refill;

  task automatic step(input bit directed, input bit do_rst,
                      input bit quiet);
    @(posedge clk);
    #1;
    if (refill && fifo.size() < 4 && $urandom_range(0, 2) != 0)
      fifo.push_back('{2'($urandom), $urandom & 32'hFFFF_FFFC,
                       rand_instr()});
    fifo_empty = (fifo.size() == 0) ||
                 (!directed && !quiet && $urandom_range(0, 7) == 0);
    if (fifo.size() != 0) {thread_id, pc, instr} = fifo[0];
    else {thread_id, pc, instr} = {2'($urandom), $urandom, $urandom};
    stall = !directed && !quiet && $urandom_range(0, 5) == 0;
    flush = !directed && !quiet && !do_rst && $urandom_range(0, 6) == 0;
    flush_thread = 2'($urandom);
    for (int k = 0; k < 4; k++)
      rdy[k] = directed || quiet || $urandom_range(0, 3) != 0;
    rst = do_rst;
    if (do_rst) rdy = '0;
    #1;
    mfire = mvalid && rdy[msel];
    mdrop = flush && !fifo_empty && fifo[0].thr == flush_thread;
    mload = !fifo_empty && !stall && (!mvalid || mfire) && !mdrop;
    mhit  = flush && mvalid && mthr == flush_thread;
    chk("valid", valid, mvalid);
    if (do_rst) begin
      chk("ack_in_rst", decode_ack, 1'b0);
      exp_q.delete();
      mvalid = 1'b0;
      return;
    end
    chk("ack", decode_ack, mload | mdrop);
    if (mload) begin
      exp_q.push_back(ref_dec(fifo[0].thr, fifo[0].pc, fifo[0].ins));
      mvalid = 1'b1;
      msel = exp_q[$].sel;
      mthr = fifo[0].thr;
    end else if (mfire || mhit) begin
      if (!mfire && exp_q.size() != 0) void'(exp_q.pop_front());
      mvalid = 1'b0;
    end
    if (mload || mdrop) void'(fifo.pop_front());
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    fifo_empty = 1'b1;
    {thread_id, pc, instr} = '0;
    stall = 1'b0;
    flush = 1'b0;
    flush_thread = '0;
    rdy = '0;
    mvalid = 1'b0;
    msel = '0;
    mthr = '0;
    refill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_outs", {rs_sel, thread_o, pc_o, imm, illegal, rd}, '0);
    chk("rst_ack", decode_ack, 1'b0);
    rst = 1'b0;

    fifo.push_back('{2'd1, 32'h100, 32'h0050_0093});
    fifo.push_back('{2'd2, 32'h104, 32'hFE00_0EE3});
    fifo.push_back('{2'd0, 32'h108, 32'hFFFF_FFFF});
    step(1, 0, 0);
    step(1, 0, 0);
    chk("addi_imm", imm, 32'd5);
    chk("addi_fields", {rs_sel, rd, thread_o, pc_o}, {2'd0, 5'd1, 2'd1, 32'h100});
    step(1, 0, 0);
    chk("beq_imm", imm, 32'hFFFF_FFFC);
    chk("beq_sel", rs_sel, 2'd1);
    step(1, 0, 0);
    chk("illegal", {rs_sel, illegal, imm}, {2'd3, 1'b1, 32'd0});

    refill = 1'b1;
    for (int c = 0; c < 3000; c++)
      step(0, c == 1500, 0);

    refill = 1'b0;
    guard = 0;
    while ((fifo.size() != 0 || mvalid) && guard < 200) begin
      step(0, 0, 1);
      guard++;
    end
    chk("drain_bound", guard < 200, 1'b1);
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
